// File: rtl/dvs_ravens_pkg.sv
// Shared DVS event layout and AER word helpers, used by the AER
// transmitter and receiver.
package dvs_ravens_pkg;

    localparam int DVS_X_ADDR_BITS = 9;
    localparam int DVS_Y_ADDR_BITS = 10;
    localparam int DVS_TS_BITS     = 16;
    localparam int AER_BITS        = 10;
    localparam int EVENT_BITS      = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + DVS_TS_BITS;

    // First member sits in the MSBs of the FIFO word.
    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0] x;
        logic [DVS_Y_ADDR_BITS-1:0] y;
        logic                       polarity;
        logic [DVS_TS_BITS-1:0]     timestamp;
    } dvs_event_t;

    function automatic logic [AER_BITS-1:0] aer_y_word(input logic [DVS_Y_ADDR_BITS-1:0] y);
        return AER_BITS'(y);
    endfunction

    function automatic logic [AER_BITS-1:0] aer_x_word(input logic [DVS_X_ADDR_BITS-1:0] x,
                                                       input logic                       pol);
        return {(AER_BITS-1)'(x), pol};
    endfunction

endpackage

// File: rtl/dvs_aer_transmitter_if.sv
// FIFO read port plus AER bus of the DVS transmitter.
// valid/ready: fifo_rd_en is a one-cycle read pulse, data follows one cycle
// later; on the AER side req/ack run a 4-phase handshake, aer/xsel stable while req=1.
interface dvs_aer_transmitter_if;
    import dvs_ravens_pkg::*;

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [EVENT_BITS-1:0] fifo_rd_data;
    logic [AER_BITS-1:0]   aer;
    logic                  xsel;
    logic                  req;
    logic                  ack;

    modport master (
        input  fifo_empty, fifo_rd_data, ack,
        output fifo_rd_en, aer, xsel, req
    );

    modport slave (
        output fifo_empty, fifo_rd_data, ack,
        input  fifo_rd_en, aer, xsel, req
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dvs_aer_transmitter.sv
// Reads DVS events from a FIFO and sends each as a Y word (skippable under
// row compression) followed by an X/polarity word over a 4-phase AER bus.
module dvs_aer_transmitter
    import dvs_ravens_pkg::*;
#(
    parameter int SETUP_CYCLES       = 2,
    parameter int ACK_TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    dvs_aer_transmitter_if.master        bus,
    input  logic                         row_compress,
    output logic                         busy,
    output logic                         ack_timeout_err,
    output logic [2:0]                   dbg_state
);

    // IDLE is encoded as zero so dbg_state reads 0 when quiescent.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SETUP   = 3'd3,
        REQ_HI  = 3'd4,
        REQ_LO  = 3'd5
    } state_e;

    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TMO_W   = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACK_TIMEOUT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic                       fifo_rd_en_q, fifo_rd_en_d;
    logic                       req_q, req_d;
    logic [AER_BITS-1:0]        aer_q, aer_d;
    logic                       xsel_q, xsel_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic                       row_valid_q, row_valid_d;
    logic [DVS_Y_ADDR_BITS-1:0] last_y_q, last_y_d;
    logic [DVS_X_ADDR_BITS-1:0] x_q, x_d;
    logic [DVS_Y_ADDR_BITS-1:0] y_q, y_d;
    logic                       pol_q, pol_d;
    logic [SETUP_W-1:0]         setup_cnt_q, setup_cnt_d;
    logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_d;

    logic       ack_s;
    dvs_event_t rd_ev;
    logic       unused_ts;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ack),
        .q   (ack_s)
    );

    assign rd_ev     = dvs_event_t'(bus.fifo_rd_data);
    // The timestamp does not travel over AER.
    assign unused_ts = ^rd_ev.timestamp;

    always_comb begin
        state_d      = state_q;
        fifo_rd_en_d = 1'b0;
        req_d        = req_q;
        aer_d        = aer_q;
        xsel_d       = xsel_q;
        busy_d       = busy_q;
        err_d        = err_q;
        row_valid_d  = row_valid_q;
        last_y_d     = last_y_q;
        x_d          = x_q;
        y_d          = y_q;
        pol_d        = pol_q;
        setup_cnt_d  = setup_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    state_d      = READ;
                    fifo_rd_en_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end

            READ: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                x_d         = rd_ev.x;
                y_d         = rd_ev.y;
                pol_d       = rd_ev.polarity;
                setup_cnt_d = '0;
                state_d     = SETUP;
                if (row_compress && row_valid_q && (rd_ev.y == last_y_q)) begin
                    aer_d  = aer_x_word(rd_ev.x, rd_ev.polarity);
                    xsel_d = 1'b1;
                end else begin
                    aer_d  = aer_y_word(rd_ev.y);
                    xsel_d = 1'b0;
                end
            end

            SETUP: begin
                // A stale ack from the previous word holds us here.
                if (setup_cnt_q == SETUP_LAST) begin
                    if (!ack_s) begin
                        state_d   = REQ_HI;
                        req_d     = 1'b1;
                        tmo_cnt_d = '0;
                    end
                end else begin
                    setup_cnt_d = setup_cnt_q + SETUP_W'(1);
                end
            end

            REQ_HI: begin
                if (ack_s) begin
                    state_d   = REQ_LO;
                    req_d     = 1'b0;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    row_valid_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            REQ_LO: begin
                if (!ack_s) begin
                    if (!xsel_q) begin
                        last_y_d    = y_q;
                        row_valid_d = 1'b1;
                        aer_d       = aer_x_word(x_q, pol_q);
                        xsel_d      = 1'b1;
                        setup_cnt_d = '0;
                        state_d     = SETUP;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    row_valid_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fifo_rd_en_q <= 1'b0;
            req_q        <= 1'b0;
            aer_q        <= '0;
            xsel_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            row_valid_q  <= 1'b0;
            last_y_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pol_q        <= 1'b0;
            setup_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            req_q        <= req_d;
            aer_q        <= aer_d;
            xsel_q       <= xsel_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            row_valid_q  <= row_valid_d;
            last_y_q     <= last_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pol_q        <= pol_d;
            setup_cnt_q  <= setup_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.fifo_rd_en  = fifo_rd_en_q;
    assign bus.req         = req_q;
    assign bus.aer         = aer_q;
    assign bus.xsel        = xsel_q;
    assign busy            = busy_q;
    assign ack_timeout_err = err_q;
    assign dbg_state       = state_q;

    a_req_only_in_req_hi : assert property (@(posedge clk) disable iff (rst)
        req_q |-> (state_q == REQ_HI));
    a_word_stable_under_req : assert property (@(posedge clk) disable iff (rst)
        req_q |-> ($stable(aer_q) && $stable(xsel_q)));

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// Bench for dvs_aer_transmitter: FIFO model, jittered AER responder and an
// event-level reference model of the expected AER word stream.
module tb_dvs_aer_transmitter;
    import dvs_ravens_pkg::*;

    localparam int         SETUP_CYCLES = 2;
    localparam int         ACK_TMO      = 1024;
    localparam logic [2:0] DBG_IDLE     = 3'd0;

    logic       clk;
    logic       rst;
    logic       row_compress;
    logic       busy;
    logic       ack_timeout_err;
    logic [2:0] dbg_state;

    dvs_aer_transmitter_if bus();

    dvs_aer_transmitter #(
        .SETUP_CYCLES       (SETUP_CYCLES),
        .ACK_TIMEOUT_CYCLES (ACK_TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .row_compress    (row_compress),
        .busy            (busy),
        .ack_timeout_err (ack_timeout_err),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rd_pulses = 0;
    int          req_rises = 0;
    int          req_hi_cycles = 0;
    int          last_change = 0;
    logic [11:0] exp_q[$];
    dvs_event_t  ev_q[$];
    logic        m_row_valid = 1'b0;
    logic [9:0]  m_last_y = '0;

    logic        resp_en = 1'b1;
    int          dly_min = 0;
    int          dly_max = 0;
    int          r_state = 0;
    int          r_delay = 0;
    logic [11:0] word_now = '0;
    logic [11:0] word_prev = '0;
    logic [11:0] cap_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: Y word unless compressed away, then the X/polarity word.
    task automatic send(input int x, input int y, input int p);
        dvs_event_t e;
        e.x         = DVS_X_ADDR_BITS'(x);
        e.y         = DVS_Y_ADDR_BITS'(y);
        e.polarity  = p[0];
        e.timestamp = DVS_TS_BITS'($urandom);
        if (!(row_compress && m_row_valid && (e.y == m_last_y)))
            exp_q.push_back({2'b00, e.y});
        exp_q.push_back({1'b0, 1'b1, e.x, e.polarity});
        m_last_y    = e.y;
        m_row_valid = 1'b1;
        ev_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req"},   bus.req, 0);
        check_eq({tag, "_rden"},  bus.fifo_rd_en, 0);
        check_eq({tag, "_aer"},   bus.aer, 0);
        check_eq({tag, "_xsel"},  bus.xsel, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_err"},   ack_timeout_err, 0);
        check_eq({tag, "_state"}, dbg_state, DBG_IDLE);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((ev_q.size() != 0 || exp_q.size() != 0 || busy || bus.req || bus.ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_drain_in_budget"}, (n < budget), 1);
        check_eq({tag, "_words_left"}, exp_q.size(), 0);
    endtask

    // ---------------- FIFO model: data valid only the cycle after rd_en ----------------
    always @(posedge clk) begin
        if (bus.fifo_rd_en && ev_q.size() > 0)
            bus.fifo_rd_data <= ev_q.pop_front();
        else
            bus.fifo_rd_data <= EVENT_BITS'({$urandom, $urandom});
        bus.fifo_empty <= (ev_q.size() == 0);
    end

    // ---------------- monitor + AER responder ----------------
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            r_state = 0;
            bus.ack = 1'b0;
        end else begin
            word_now = {1'b0, bus.xsel, bus.aer};
            if (word_now != word_prev) last_change = cyc;
            word_prev = word_now;
            if (bus.fifo_rd_en) begin
                rd_pulses++;
                check_eq("rd_nonempty", (ev_q.size() != 0), 1);
                check_eq("rd_bus_idle", {bus.req, bus.ack}, 0);
            end
            if (bus.req) req_hi_cycles++;
            case (r_state)
                0: if (bus.req) begin
                    req_rises++;
                    cap_word = word_now;
                    check_eq("setup_time", ((cyc - last_change) >= SETUP_CYCLES), 1);
                    if (exp_q.size() != 0) check_eq("aer_word", word_now, exp_q.pop_front());
                    else                   check_eq("aer_extra", word_now, 12'hFFF);
                    r_delay = $urandom_range(dly_max, dly_min);
                    r_state = 1;
                end
                1: if (!bus.req) begin
                    r_state = 0;
                end else if (r_delay == 0) begin
                    if (resp_en) begin
                        bus.ack = 1'b1;
                        r_state = 2;
                    end
                end else begin
                    r_delay--;
                end
                2: if (!bus.req) begin
                    check_eq("word_hold", word_now, cap_word);
                    r_delay = $urandom_range(dly_max, dly_min);
                    r_state = 3;
                end
                default: if (r_delay == 0) begin
                    bus.ack = 1'b0;
                    r_state = 0;
                end else begin
                    r_delay--;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r0, q0, h0, n;
        rst          = 1'b1;
        row_compress = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_state", dbg_state, DBG_IDLE);

        // empty FIFO: no reads, no requests
        r0 = rd_pulses; q0 = req_rises;
        repeat (50) @(negedge clk);
        check_eq("empty_rd_pulses", rd_pulses - r0, 0);
        check_eq("empty_req_rises", req_rises - q0, 0);

        // single event, ack after 3 cycles: Y50 then X 201
        dly_min = 3; dly_max = 3;
        r0 = rd_pulses; q0 = req_rises;
        send(100, 50, 1);
        drain("single", 400);
        check_eq("single_rd_pulses", rd_pulses - r0, 1);
        check_eq("single_words", req_rises - q0, 2);
        check_eq("single_busy_end", busy, 0);

        // row compression on / off
        dly_min = 0; dly_max = 2;
        row_compress = 1'b1;
        q0 = req_rises;
        send(1, 7, 0);
        send(2, 7, 1);
        drain("cmp_on", 600);
        check_eq("cmp_on_words", req_rises - q0, 3);
        row_compress = 1'b0;
        q0 = req_rises;
        send(1, 7, 0);
        send(2, 7, 1);
        drain("cmp_off", 600);
        check_eq("cmp_off_words", req_rises - q0, 4);

        // randomized batches with ack jitter
        for (int b = 0; b < 4; b++) begin
            row_compress = 1'($urandom_range(0, 1));
            dly_min = 0;
            dly_max = $urandom_range(1, 6);
            r0 = rd_pulses;
            for (int i = 0; i < 15; i++) begin
                int y;
                y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 1023);
                send($urandom_range(0, 511), y, $urandom_range(0, 1));
            end
            drain("rand", 5000);
            check_eq("rand_rd_pulses", rd_pulses - r0, 15);
        end

        // ack timeout, then compression must restart with a Y word
        dly_min = 1; dly_max = 1;
        row_compress = 1'b1;
        send(3, 9, 0);
        drain("pre_tmo", 400);
        check_eq("pre_tmo_err", ack_timeout_err, 0);
        resp_en = 1'b0;
        h0 = req_hi_cycles;
        send(4, 9, 1);
        n = 0;
        while (!ack_timeout_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_flag", ack_timeout_err, 1);
        check_eq("tmo_req_cycles", req_hi_cycles - h0, ACK_TMO);
        check_eq("tmo_req_low", bus.req, 0);
        check_eq("tmo_state", dbg_state, DBG_IDLE);
        check_eq("tmo_busy", busy, 0);
        m_row_valid = 1'b0;
        resp_en = 1'b1;
        q0 = req_rises;
        send(5, 9, 0);
        drain("post_tmo", 400);
        check_eq("post_tmo_words", req_rises - q0, 2);
        check_eq("tmo_err_sticky", ack_timeout_err, 1);

        // asynchronous reset in the middle of REQ_HI
        resp_en = 1'b0;
        send(6, 12, 0);
        n = 0;
        while (!bus.req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_rst_req_seen", bus.req, 1);
        #1 rst = 1'b1;
        #1 check_reset_vals("mid_rst");
        exp_q.delete();
        m_row_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        r0 = rd_pulses; q0 = req_rises;
        repeat (20) @(negedge clk);
        check_eq("quiet_rd_pulses", rd_pulses - r0, 0);
        check_eq("quiet_req_rises", req_rises - q0, 0);
        row_compress = 1'b1;
        send(7, 12, 1);
        drain("recover", 400);
        check_eq("recover_words", req_rises - q0, 2);
        check_eq("final_busy", busy, 0);
        check_eq("final_state", dbg_state, DBG_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dvs_aer_transmitter.md
DVS_AER_TRANSMITTER -- requirements
Module: dvs_aer_transmitter

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, number of cycles aer/xsel are held stable before req rises.
REQ-002 Parameter ACK_TIMEOUT_CYCLES, default 1024, number of cycles in which ack must follow a req edge.
REQ-003 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  high when the event FIFO holds no events.
REQ-006 fifo_rd_en  output  1  one-cycle FIFO read pulse.
REQ-007 fifo_rd_data  input  EVENT_BITS  event word; valid the cycle after fifo_rd_en.
REQ-008 row_compress  input  1  static control; when high, the Y word is skipped if y equals the last sent y.
REQ-009 aer  output  10  AER address bus.
REQ-010 xsel  output  1  0 = Y word, 1 = X/polarity word.
REQ-011 req  output  1  AER request, 4-phase protocol, active-high.
REQ-012 ack  input  1  AER acknowledge, asynchronous to clk, active-high.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 ack_timeout_err  output  1  sticky flag; set on an ack timeout.

Function
REQ-015 FSM states: IDLE, READ, CAPTURE, SETUP, REQ_HI, REQ_LO.
REQ-016 IDLE: if fifo_empty=0, go to READ; else stay.
REQ-017 READ: fifo_rd_en=1 for exactly this one cycle; go to CAPTURE.
REQ-018 CAPTURE: register x, y and polarity from fifo_rd_data; discard the timestamp field.
REQ-019 CAPTURE word selection: select the Y word, except when row_compress=1, row_valid=1 and y equals last_y, then select the X word directly.
REQ-020 Y word encoding: aer = y zero-extended to 10 bits; xsel=0.
REQ-021 X word encoding: aer = {x zero-extended to 9 bits, polarity}; xsel=1.
REQ-022 SETUP: drive the selected word with req=0 for SETUP_CYCLES cycles; then go to REQ_HI.
REQ-023 aer and xsel are registered and change only on entry to SETUP or in reset.
REQ-024 ack passes through a 2-flop synchronizer; FSM decisions use only the synchronized ack (ack_s).
REQ-025 REQ_HI: req=1 until ack_s=1; then go to REQ_LO.
REQ-026 REQ_LO: req=0 until ack_s=0.
REQ-027 REQ_LO exit after a Y word: set last_y=y and row_valid=1; go to SETUP with the X word.
REQ-028 REQ_LO exit after an X word: go to IDLE.
REQ-029 A timeout counter clears on entry to REQ_HI and to REQ_LO and increments each cycle in those states.
REQ-030 If the timeout counter reaches ACK_TIMEOUT_CYCLES: set ack_timeout_err, clear row_valid, drop req and go to IDLE; the event is abandoned.
REQ-031 fifo_empty is sampled only in IDLE; fifo_rd_en is never asserted while fifo_empty=1.
REQ-032 At most one event is in flight at a time; no FIFO read occurs before the X handshake completes.
REQ-033 Minimum per-event latency, IDLE to IDLE with ack immediate: READ, CAPTURE, then two words each costing SETUP_CYCLES plus the ack round trip.
REQ-034 ack_s=1 seen in IDLE, READ, CAPTURE or SETUP is ignored; in SETUP, REQ_HI is entered only after ack_s=0.

Reset
REQ-035 rst=1 forces state=IDLE immediately, regardless of the current state.
REQ-036 Reset values: req=0, fifo_rd_en=0, aer=0, xsel=0, busy=0, ack_timeout_err=0, row_valid=0, counters=0, synchronizer flops=0.
REQ-037 Reset mid-handshake drops req with no further AER activity; an event already read from the FIFO is lost.

Structure
REQ-038 dvs_ravens_pkg provides EVENT_BITS, DVS_X_ADDR_BITS (max 9) and DVS_Y_ADDR_BITS (max 10).
REQ-039 dvs_ravens_pkg adds a packed struct typedef for the event layout, shared with dvs_aer_receiver: x, y, polarity, timestamp.
REQ-040 The FSM state enum is defined locally in this module.
REQ-041 The ack synchronizer is a sub-module named sync_2ff.

Verification
REQ-042 Event x=100, y=50, pol=1, responder ack after 3 cycles -> aer=50/xsel=0, then aer=201/xsel=1; one fifo_rd_en pulse; busy low at end.
REQ-043 row_compress=1, events (y=7,x=1) then (y=7,x=2) -> words: Y7, X, X; row_compress=0 -> Y7, X, Y7, X.
REQ-044 ack held 0 -> req high for 1024 cycles, then ack_timeout_err=1 and state IDLE; the next event is sent with its Y word even under compression.
REQ-045 rst pulsed during REQ_HI -> req=0 asynchronously, no fifo_rd_en for the rest of that cycle, all outputs at reset values.
REQ-046 fifo_empty=1 throughout -> fifo_rd_en never pulses, req stays 0.
REQ-047 Loopback into dvs_aer_receiver with random events and ack jitter -> the received x/y/polarity sequence equals the sent sequence.
